// File: rtl/draw_pkg.sv
// Shared definitions for the draw_* family of blocks.
//   - Default screen geometry (160 x 120) and colour depth.
//   - Coordinate widths: x is 8 bits, y is 7 bits; the unclipped sums carry
//     one extra bit so that off-screen positions can be detected.
//   - Blitter FSM state encoding.
package draw_pkg;

  localparam int SCR_W_DEF   = 160;
  localparam int SCR_H_DEF   = 120;
  localparam int COLOR_W_DEF = 3;

  localparam int X_W  = 8;
  localparam int Y_W  = 7;
  localparam int SX_W = X_W + 1;
  localparam int SY_W = Y_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } draw_state_t;

endpackage

// File: rtl/draw_rom_image_if.sv
// Bus bundle for draw_rom_image.
//   start/x_org/y_org  draw request and screen origin (from the game FSM)
//   busy/done          draw status back to the game FSM
//   rom_addr/rom_q     synchronous image ROM port
//   x_out/y_out/c_out/plot  VGA adapter pixel port
// Modports:
//   master  the surrounding system (game FSM, image ROM, VGA adapter)
//   slave   the blitter itself
interface draw_rom_image_if
  import draw_pkg::*;
#(
  parameter int ADDR_W  = 15,
  parameter int COLOR_W = COLOR_W_DEF
);

  logic               start;
  logic [X_W-1:0]     x_org;
  logic [Y_W-1:0]     y_org;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  rom_addr;
  logic [COLOR_W-1:0] rom_q;
  logic [X_W-1:0]     x_out;
  logic [Y_W-1:0]     y_out;
  logic [COLOR_W-1:0] c_out;
  logic               plot;

  modport master (
    output start, x_org, y_org, rom_q,
    input  busy, done, rom_addr, x_out, y_out, c_out, plot
  );

  modport slave (
    input  start, x_org, y_org, rom_q,
    output busy, done, rom_addr, x_out, y_out, c_out, plot
  );

endinterface

// File: rtl/draw_delay_line.sv
// Fixed-depth delay line used to keep per-pixel side information aligned
// with a pipelined memory read.
//   clk, resetn   clock, asynchronous active-low reset (clears valids only)
//   in_vld        valid flag entering the line
//   in_data       payload entering the line
//   out_vld       in_vld delayed by DEPTH cycles
//   out_data      in_data delayed by DEPTH cycles
// Parameters: DEPTH (>=1) stages, WIDTH payload bits.
module draw_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_sr;
  logic [WIDTH-1:0] data_sr [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= in_vld;
      for (int i = 1; i < DEPTH; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  // Payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    data_sr[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) data_sr[i] <= data_sr[i-1];
  end

  assign out_vld  = vld_sr[DEPTH-1];
  assign out_data = data_sr[DEPTH-1];

endmodule

// File: rtl/draw_rom_image.sv
// ROM-to-framebuffer blitter.
// On an accepted start it reads an IMG_W x IMG_H image from a synchronous
// ROM (latency ROM_LAT) in row-major order, one address per cycle, and
// emits each pixel at screen position (x_org+col, y_org+row). Pixels that
// fall outside SCR_W x SCR_H are not plotted, but are still read so the
// draw time is independent of the origin.
//   clk      system clock
//   resetn   asynchronous active-low reset; aborts any draw in progress
//   bus      draw_rom_image_if.slave:
//              start/x_org/y_org in, busy/done out,
//              rom_addr out / rom_q in,
//              x_out/y_out/c_out/plot out (VGA pixel port)
// Optional feature (compile-time macro DRAW_TRANSPARENCY_EN):
//   when defined, pixels whose ROM colour equals KEY_COLOR are not plotted.
//   When undefined, KEY_COLOR has no effect.
// Timing: start accepted in cycle 0, first address in cycle 1, pixel issued
// in cycle k appears on the pixel port in cycle k+ROM_LAT+1, done pulses in
// cycle IMG_W*IMG_H+ROM_LAT+2.
module draw_rom_image
  import draw_pkg::*;
#(
  parameter int IMG_W     = 160,
  parameter int IMG_H     = 120,
  parameter int SCR_W     = SCR_W_DEF,
  parameter int SCR_H     = SCR_H_DEF,
  parameter int COLOR_W   = COLOR_W_DEF,
  parameter int ADDR_W    = 15,
  parameter int ROM_LAT   = 2,
  parameter int KEY_COLOR = 0
) (
  input  logic              clk,
  input  logic              resetn,
  draw_rom_image_if.slave   bus
);

  localparam int                NPIX      = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [X_W-1:0]    COL_LAST  = X_W'(IMG_W - 1);
  localparam int                DR_W      = $clog2(ROM_LAT + 1) + 1;
  localparam logic [DR_W-1:0]   DR_LAST   = DR_W'(ROM_LAT);
  localparam int                LINE_W    = SX_W + SY_W;

  function automatic logic on_screen(input logic [SX_W-1:0] sx,
                                     input logic [SY_W-1:0] sy);
    return (int'(sx) < SCR_W) && (int'(sy) < SCR_H);
  endfunction

  draw_state_t        state;
  logic [ADDR_W-1:0]  addr_p0;
  logic [X_W-1:0]     col_p0;
  logic [Y_W-1:0]     row_p0;
  logic [DR_W-1:0]    drain_cnt;
  logic               busy_r;
  logic               done_r;
  logic [X_W-1:0]     xo_r;
  logic [Y_W-1:0]     yo_r;

  logic               vld_p0;
  logic [SX_W-1:0]    sx_p0;
  logic [SY_W-1:0]    sy_p0;

  logic               vld_p1;
  logic [LINE_W-1:0]  line_p1;
  logic [SX_W-1:0]    sx_p1;
  logic [SY_W-1:0]    sy_p1;
  logic               keep_p1;
  logic               plot_p1;

  logic               plot_p2;
  logic [X_W-1:0]     x_p2;
  logic [Y_W-1:0]     y_p2;
  logic [COLOR_W-1:0] c_p2;

  // Control FSM: one ROM address per SCAN cycle, then wait out the ROM
  // latency plus the output register before signalling done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      addr_p0   <= '0;
      col_p0    <= '0;
      row_p0    <= '0;
      drain_cnt <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= SCAN;
            addr_p0 <= '0;
            col_p0  <= '0;
            row_p0  <= '0;
            busy_r  <= 1'b1;
          end
        end
        SCAN: begin
          if (addr_p0 == LAST_ADDR) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            // Running address counter; col/row only feed the coordinates.
            addr_p0 <= addr_p0 + ADDR_W'(1);
            if (col_p0 == COL_LAST) begin
              col_p0 <= '0;
              row_p0 <= row_p0 + Y_W'(1);
            end else begin
              col_p0 <= col_p0 + X_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DR_LAST) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DR_W'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Origin is captured with the accepted start and held for the whole draw.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      xo_r <= bus.x_org;
      yo_r <= bus.y_org;
    end
  end

  // ---- stage p0: address issue, unclipped screen coordinates ----
  always_comb begin
    vld_p0 = (state == SCAN);
    sx_p0  = {1'b0, xo_r} + {1'b0, col_p0};
    sy_p0  = {1'b0, yo_r} + {1'b0, row_p0};
  end

  // ---- stage p0 -> p1: side information travels with the ROM read ----
  draw_delay_line #(
    .DEPTH (ROM_LAT),
    .WIDTH (LINE_W)
  ) u_delay (
    .clk      (clk),
    .resetn   (resetn),
    .in_vld   (vld_p0),
    .in_data  ({sx_p0, sy_p0}),
    .out_vld  (vld_p1),
    .out_data (line_p1)
  );

  assign sx_p1 = line_p1[LINE_W-1 -: SX_W];
  assign sy_p1 = line_p1[SY_W-1:0];

`ifdef DRAW_TRANSPARENCY_EN
  localparam logic [COLOR_W-1:0] KEY = COLOR_W'(KEY_COLOR);
  assign keep_p1 = (bus.rom_q != KEY);
`else
  // KEY_COLOR has no effect in this build.
  logic unused_key;
  assign unused_key = ^32'(KEY_COLOR);
  assign keep_p1    = 1'b1;
`endif

  assign plot_p1 = vld_p1 && on_screen(sx_p1, sy_p1) && keep_p1;

  // ---- stage p1 -> p2: pixel port register; values hold when not plotting ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot_p2 <= 1'b0;
      x_p2    <= '0;
      y_p2    <= '0;
      c_p2    <= '0;
    end else begin
      plot_p2 <= plot_p1;
      if (plot_p1) begin
        x_p2 <= sx_p1[X_W-1:0];
        y_p2 <= sy_p1[Y_W-1:0];
        c_p2 <= bus.rom_q;
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.rom_addr = addr_p0;
  assign bus.x_out    = x_p2;
  assign bus.y_out    = y_p2;
  assign bus.c_out    = c_p2;
  assign bus.plot     = plot_p2;

endmodule

// File: tb/tb_draw_rom_image.sv
// Testbench for draw_rom_image: a full-screen 160x120 instance and an 8x4
// sprite instance, each fed by a behavioural ROM with 2-cycle latency.
module tb_draw_rom_image;

  localparam int L    = 2;
  localparam int SCRW = 160;
  localparam int SCRH = 120;
  localparam int BW = 160, BH = 120, BN = BW * BH;
  localparam int SW = 8,   SH = 4,   SN = SW * SH;
`ifdef DRAW_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic brstn = 1'b1;
  logic srstn = 1'b1;
  int   errors = 0;
  int   checks = 0;

  draw_rom_image_if #(.ADDR_W(15), .COLOR_W(3)) bbus ();
  draw_rom_image_if #(.ADDR_W(5),  .COLOR_W(3)) sbus ();

  draw_rom_image #(
    .IMG_W(BW), .IMG_H(BH), .SCR_W(SCRW), .SCR_H(SCRH), .COLOR_W(3),
    .ADDR_W(15), .ROM_LAT(L), .KEY_COLOR(0)
  ) u_big (.clk(clk), .resetn(brstn), .bus(bbus));

  draw_rom_image #(
    .IMG_W(SW), .IMG_H(SH), .SCR_W(SCRW), .SCR_H(SCRH), .COLOR_W(3),
    .ADDR_W(5), .ROM_LAT(L), .KEY_COLOR(0)
  ) u_small (.clk(clk), .resetn(srstn), .bus(sbus));

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic keep(input int colour);
    return (colour != 0) || !TRANSP;
  endfunction

  // Behavioural ROMs: big image q = addr[2:0], sprite image from a table.
  logic [2:0] srom      [SN];
  logic [2:0] brom_pipe [L];
  logic [2:0] srom_pipe [L];
  always @(posedge clk) begin
    brom_pipe[0] <= bbus.rom_addr[2:0];
    srom_pipe[0] <= srom[sbus.rom_addr];
    for (int i = 1; i < L; i++) begin
      brom_pipe[i] <= brom_pipe[i-1];
      srom_pipe[i] <= srom_pipe[i-1];
    end
  end
  assign bbus.rom_q = brom_pipe[L-1];
  assign sbus.rom_q = srom_pipe[L-1];

  // Sprite reference model: timing derived from the accepted-start cycle.
  int         s_cyc = 0;
  int         s_t0 = -1;
  int         s_nx = 0, s_ny = 0;
  int         s_next_free = 0;
  logic [7:0] s_lx = '0;
  logic [6:0] s_ly = '0;
  logic [2:0] s_lc = '0;

  always @(posedge clk) s_cyc <= s_cyc + 1;

  always @(negedge clk) begin : s_model
    int rel, a, sx, sy;
    logic pe;
    logic [7:0] ex_x;
    logic [6:0] ex_y;
    logic [2:0] ex_c;
    if (!srstn) begin
      check_val("s_rst_plot", sbus.plot, 0);
      check_val("s_rst_busy", sbus.busy, 0);
      check_val("s_rst_done", sbus.done, 0);
      check_val("s_rst_x", sbus.x_out, 0);
      check_val("s_rst_c", sbus.c_out, 0);
      s_t0 <= -1;
      s_next_free <= 0;
      s_lx <= '0; s_ly <= '0; s_lc <= '0;
    end else begin
      pe = 1'b0; ex_x = s_lx; ex_y = s_ly; ex_c = s_lc;
      rel = s_cyc - s_t0 - (L + 2);
      if (s_t0 >= 0 && rel >= 0 && rel < SN) begin
        sx = s_nx + rel % SW;
        sy = s_ny + rel / SW;
        pe = (sx < SCRW) && (sy < SCRH) && keep(int'(srom[rel]));
        if (pe) begin
          ex_x = 8'(sx); ex_y = 7'(sy); ex_c = srom[rel];
        end
      end
      check_val("s_plot", sbus.plot, pe);
      check_val("s_x", sbus.x_out, ex_x);
      check_val("s_y", sbus.y_out, ex_y);
      check_val("s_c", sbus.c_out, ex_c);
      check_val("s_busy", sbus.busy,
                (s_t0 >= 0) && (s_cyc >= s_t0 + 1) && (s_cyc <= s_t0 + SN + L + 1));
      check_val("s_done", sbus.done, (s_t0 >= 0) && (s_cyc == s_t0 + SN + L + 2));
      a = s_cyc - s_t0 - 1;
      if (s_t0 >= 0 && a >= 0 && a < SN) check_val("s_addr", sbus.rom_addr, a);
      s_lx <= ex_x; s_ly <= ex_y; s_lc <= ex_c;
      if (sbus.start && s_cyc >= s_next_free) begin
        s_t0 <= s_cyc;
        s_nx <= int'(sbus.x_org);
        s_ny <= int'(sbus.y_org);
        s_next_free <= s_cyc + SN + L + 3;
      end
    end
  end

  task automatic s_step();
    @(posedge clk);
    #2;
  endtask

  task automatic s_wait_idle();
    s_step();
    for (int k = 0; k < 400 && s_cyc < s_next_free; k++) s_step();
  endtask

  task automatic s_go(input int xo, input int yo, input int hold);
    s_wait_idle();
    sbus.x_org = 8'(xo);
    sbus.y_org = 7'(yo);
    sbus.start = 1'b1;
    repeat (hold) s_step();
    sbus.start = 1'b0;
  endtask

  task automatic s_fill(input int lo);
    for (int i = 0; i < SN; i++) srom[i] = 3'($urandom_range(lo, 7));
  endtask

  task automatic small_seq();
    s_fill(0);
    repeat (3) s_step();
    srstn = 1'b1;
    s_go(10, 20, 1);                 // fully on-screen sprite
    s_go(156, 118, 1);               // clipped at right and bottom edges
    // Pulse mid-SCAN is ignored; start held across DONE re-triggers.
    s_go(40, 50, 1);
    repeat (6) s_step();
    sbus.x_org = 8'd0; sbus.y_org = 7'd0; sbus.start = 1'b1;
    s_step();
    sbus.start = 1'b0;
    for (int k = 0; k < 400 && s_cyc < s_next_free - 3; k++) s_step();
    sbus.x_org = 8'd70; sbus.y_org = 7'd30; sbus.start = 1'b1;
    repeat (4) s_step();
    sbus.start = 1'b0;
    // Key colour at pixel 5, all others non-key.
    s_wait_idle();
    s_fill(1);
    srom[5] = 3'd0;
    s_go(0, 0, 1);
    for (int n = 0; n < 12; n++) begin
      s_wait_idle();
      s_fill(0);
      s_go(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
           int'($urandom_range(1, 2)));
    end
    // Reset in the middle of a draw.
    s_go(20, 10, 1);
    repeat ($urandom_range(5, 30)) s_step();
    srstn = 1'b0;
    repeat (2) s_step();
    srstn = 1'b1;
    repeat (20) s_step();
    s_wait_idle();
    repeat (5) s_step();
  endtask

  task automatic big_seq();
    int p, bplots, bdones;
    logic e;
    @(negedge clk);
    check_val("b_rst_plot", bbus.plot, 0);
    check_val("b_rst_busy", bbus.busy, 0);
    check_val("b_rst_done", bbus.done, 0);
    check_val("b_rst_addr", bbus.rom_addr, 0);
    check_val("b_rst_x", bbus.x_out, 0);
    check_val("b_rst_y", bbus.y_out, 0);
    @(posedge clk);
    #2 brstn = 1'b1;
    // Full-screen draw, origin (0,0); start sampled at the end of cycle 0.
    @(negedge clk);
    bbus.x_org = 8'd0; bbus.y_org = 7'd0; bbus.start = 1'b1;
    bplots = 0; bdones = 0;
    for (int c = 1; c <= BN + L + 5; c++) begin
      @(negedge clk);
      if (c == 1) bbus.start = 1'b0;
      p = c - (L + 2);
      e = (p >= 0 && p < BN) ? keep(p % 8) : 1'b0;
      check_val("b_plot", bbus.plot, e);
      if (e) begin
        check_val("b_x", bbus.x_out, p % BW);
        check_val("b_y", bbus.y_out, p / BW);
        check_val("b_c", bbus.c_out, p % 8);
      end
      if (bbus.plot) bplots++;
      if (bbus.done) bdones++;
      check_val("b_busy", bbus.busy, (c >= 1) && (c <= BN + L + 1));
      check_val("b_done", bbus.done, c == BN + L + 2);
      if (c <= BN) check_val("b_addr", bbus.rom_addr, c - 1);
    end
    check_val("b_nplots", bplots, TRANSP ? BN - BN / 8 : BN);
    check_val("b_ndone", bdones, 1);
    check_val("b_hold_x", bbus.x_out, 159);
    check_val("b_hold_y", bbus.y_out, 119);
    check_val("b_hold_c", bbus.c_out, 7);
    // Reset asserted at the 100th plot.
    @(negedge clk);
    bbus.start = 1'b1;
    bplots = 0;
    for (int c = 1; c <= 400 && bplots < 100; c++) begin
      @(negedge clk);
      if (c == 1) bbus.start = 1'b0;
      if (bbus.plot) bplots++;
    end
    check_val("b_t5_reach", bplots, 100);
    brstn = 1'b0;
    #1;
    check_val("b_t5_plot", bbus.plot, 0);
    check_val("b_t5_busy", bbus.busy, 0);
    check_val("b_t5_done", bbus.done, 0);
    @(posedge clk);
    #2 brstn = 1'b1;
    repeat (40) begin
      @(negedge clk);
      check_val("b_t5_noplot", bbus.plot, 0);
      check_val("b_t5_idle", bbus.busy, 0);
    end
  endtask

  initial begin
    bbus.start = 1'b0; bbus.x_org = '0; bbus.y_org = '0;
    sbus.start = 1'b0; sbus.x_org = '0; sbus.y_org = '0;
    for (int i = 0; i < SN; i++) srom[i] = '0;
    #1;
    brstn = 1'b0;
    srstn = 1'b0;
    fork
      big_seq();
      small_seq();
    join
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
